uart_rx: RTL and testbench

- Receive-side companion of the UART transmitter; deserialises the FPGA's incoming UART line into bytes for the command/console path of the SATA example.
- Front end: 2-FF synchroniser, then a start/data/parity/stop FSM sampling at bit centres.
- Output: one-cycle byte-valid strobe with parity and framing status; no backpressure.

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-FF sync, centre-sampled start/data/parity/stop FSM.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx #(
  parameter int    CLK_DIV = 434,
  parameter string PARITY  = "NONE"
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_en,
  output logic       rx_parity_err,
  output logic       rx_frame_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
  localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);

  logic       sync1;
  logic       rxs;
  logic       rxs_d;
  logic       bit_s;
  logic [2:0] state;
  logic [15:0] cnt;
  logic [3:0] bit_idx;
  logic [7:0] shift;
  logic       par_err;
  logic       sample_pt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Decision lands on centre+1, so the start point (and every later one) moves one cycle.
  localparam logic [15:0] START_CNT = 16'(CLK_DIV / 2);
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rxs};
    end
  end

  assign bit_s = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  localparam logic [15:0] START_CNT = 16'(CLK_DIV / 2 - 1);
  assign bit_s = rxs;
`endif

  assign sample_pt = (state == S_START) ? (cnt == START_CNT) : (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      cnt           <= 16'd0;
      bit_idx       <= 4'd0;
      shift         <= 8'd0;
      par_err       <= 1'b0;
      rx_data       <= 8'd0;
      rx_en         <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_en <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt     <= 16'd0;
          bit_idx <= 4'd0;
          par_err <= 1'b0;
          if (!rxs && rxs_d) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (sample_pt) begin
            cnt   <= 16'd0;
            state <= bit_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (sample_pt) begin
            cnt   <= 16'd0;
            shift <= {bit_s, shift[7:1]};
            if (bit_idx == 4'd7) begin
              bit_idx <= 4'd0;
              state   <= PAR_EN ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (sample_pt) begin
            cnt     <= 16'd0;
            par_err <= (^shift) ^ bit_s ^ PAR_ODD;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (sample_pt) begin
            cnt           <= 16'd0;
            rx_en         <= 1'b1;
            rx_data       <= shift;
            rx_parity_err <= par_err;
            rx_frame_err  <= ~bit_s;
            state         <= bit_s ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_BREAK: begin
          // A held-low line must go high before another start edge is accepted.
          cnt <= 16'd0;
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (CLK_DIV=8, NONE and EVEN instances).
module tb_uart_rx;

  localparam int DIV = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    bit         sel;
    logic [7:0] d;
    bit         use_par;
    bit         p;
    bit         stop;
    logic [7:0] exp_d;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic line_n = 1'b1;
  logic line_e = 1'b1;
  logic [7:0] rx_data_n, rx_data_e;
  logic rx_en_n, rx_en_e, rx_perr_n, rx_perr_e, rx_ferr_n, rx_ferr_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt_n = 0, en_cnt_e = 0;
  int push_n = 0, push_e = 0;
  int en_cyc_n = 0;
  exp_t exp_n[$];
  exp_t exp_e[$];
  exp_t got_n, got_e;

  uart_rx #(.CLK_DIV(DIV), .PARITY("NONE")) dut_n (
    .clk(clk), .rstn(rstn), .i_uart_rx(line_n), .rx_data(rx_data_n),
    .rx_en(rx_en_n), .rx_parity_err(rx_perr_n), .rx_frame_err(rx_ferr_n)
  );

  uart_rx #(.CLK_DIV(DIV), .PARITY("EVEN")) dut_e (
    .clk(clk), .rstn(rstn), .i_uart_rx(line_e), .rx_data(rx_data_e),
    .rx_en(rx_en_e), .rx_parity_err(rx_perr_e), .rx_frame_err(rx_ferr_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d;
    e.pe = pe;
    e.fe = fe;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rx_en_n) begin
      en_cnt_n++;
      en_cyc_n = cyc;
      if (exp_n.size() == 0) begin
        check("n_unexpected_rx_en", 32'd1, 32'd0);
      end else begin
        got_n = exp_n.pop_front();
        check("n_rx_data", {24'd0, rx_data_n}, {24'd0, got_n.d});
        check("n_parity_err", {31'd0, rx_perr_n}, {31'd0, got_n.pe});
        check("n_frame_err", {31'd0, rx_ferr_n}, {31'd0, got_n.fe});
      end
    end
    if (rx_en_e) begin
      en_cnt_e++;
      if (exp_e.size() == 0) begin
        check("e_unexpected_rx_en", 32'd1, 32'd0);
      end else begin
        got_e = exp_e.pop_front();
        check("e_rx_data", {24'd0, rx_data_e}, {24'd0, got_e.d});
        check("e_parity_err", {31'd0, rx_perr_e}, {31'd0, got_e.pe});
        check("e_frame_err", {31'd0, rx_ferr_e}, {31'd0, got_e.fe});
      end
    end
  end

  task automatic drive(input bit sel, input bit v);
    if (sel) line_e = v;
    else line_n = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit use_par, input bit p,
                      input bit stop, input exp_t e);
    if (sel) begin
      exp_e.push_back(e);
      push_e++;
    end else begin
      exp_n.push_back(e);
      push_n++;
    end
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (use_par) drive(sel, p);
    drive(sel, stop);
  endtask

  vec_t tbl[9];
  int c0;
  int start_cyc;
  logic [7:0] rdat;

  initial begin
    tbl[0] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_rx_en", {31'd0, rx_en_n}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data_n}, 32'd0);
    check("reset_flags", {30'd0, rx_perr_n, rx_ferr_n}, 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // first frame: byte and pin-to-strobe latency
    start_cyc = cyc;
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, mk(8'h55, 1'b0, 1'b0));
    check("latency_0x55", en_cyc_n - start_cyc, 32'd79);
    check("one_rx_en_0x55", en_cnt_n, 32'd1);
    repeat (DIV) @(negedge clk);

    c0 = en_cnt_n;
    line_n = 1'b0;
    repeat (2) @(negedge clk);
    line_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("glitch_no_rx_en", en_cnt_n - c0, 32'd0);
    send(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1, mk(8'hA3, 1'b0, 1'b0));
    repeat (DIV) @(negedge clk);

    c0 = en_cnt_n;
    exp_n.push_back(mk(8'h00, 1'b0, 1'b1));
    push_n++;
    line_n = 1'b0;
    repeat (20 * DIV) @(negedge clk);
    check("break_one_rx_en", en_cnt_n - c0, 32'd1);
    line_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("break_no_extra_rx_en", en_cnt_n - c0, 32'd1);
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, mk(8'h5A, 1'b0, 1'b0));
    repeat (DIV) @(negedge clk);

    c0 = en_cnt_n;
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, mk(8'h00, 1'b0, 1'b0));
    send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, mk(8'hFF, 1'b0, 1'b0));
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, mk(8'h3C, 1'b0, 1'b0));
    repeat (DIV) @(negedge clk);
    check("back_to_back_count", en_cnt_n - c0, 32'd3);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].sel, tbl[i].d, tbl[i].use_par, tbl[i].p, tbl[i].stop,
           mk(tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe));
      line_n = 1'b1;
      line_e = 1'b1;
      repeat (2 * DIV) @(negedge clk);
    end

    // abandon a frame partway through bit 4
    c0 = en_cnt_n;
    rdat = 8'h6B;
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, rdat[i]);
    line_n = rdat[4];
    repeat (DIV / 2) @(negedge clk);
    rstn = 1'b0;
    line_n = 1'b1;
    #1;
    check("midreset_rx_data_n", {24'd0, rx_data_n}, 32'd0);
    check("midreset_frame_err_n", {31'd0, rx_ferr_n}, 32'd0);
    check("midreset_parity_err_e", {31'd0, rx_perr_e}, 32'd0);
    check("midreset_rx_data_e", {24'd0, rx_data_e}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    check("midreset_no_rx_en", en_cnt_n - c0, 32'd0);
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, mk(8'h81, 1'b0, 1'b0));

    for (int i = 0; i < 40 * DIV && (exp_n.size() != 0 || exp_e.size() != 0); i++)
      @(negedge clk);
    repeat (2 * DIV) @(negedge clk);
    check("drain_n", exp_n.size(), 32'd0);
    check("drain_e", exp_e.size(), 32'd0);
    check("total_rx_en_n", en_cnt_n, push_n);
    check("total_rx_en_e", en_cnt_e, push_e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
